ins_write_back: RTL and testbench
=================================

Name: ins_write_back

Overview:
- Commit stage directly downstream of the instruction-execute stage.
- Consumes one execute result per `op` pulse:
  - register write request
  - store request
  - PC-redirect request
- Performs the store through a req/ack memory port, then issues a single-cycle commit of register file and PC in program order.
- Flags misaligned control transfers and store timeouts, and pulses `done` so the sequencer can fetch the next instruction.

Parameters:
TIMEOUT_CYCLES, 16, max MEM_WAIT cycles without mem_ack before store is abandoned (1..255)
CNT_W, 8, width of store wait counter; must hold TIMEOUT_CYCLES

Ports:
sys_clk  in  1  clock; all state updates on rising edge
sys_rst  in  1  synchronous active-high reset
op  in  1  execute result valid, one-cycle pulse, sampled at rising edge
reg_w_op  in  1  execute requests rd write
reg_w_reg_idx  in  5  rd index
reg_w_reg_val  in  32  rd value
mem_w_op  in  1  execute requests word store
mem_w_mem_addr  in  32  store address
mem_w_mem_val  in  32  store data (already byte-merged by execute)
reg_pc_w_op  in  1  execute requests PC redirect
reg_pc_w_val  in  32  redirect target
reg_pc_val  in  32  PC of the committing instruction
mem_ack  in  1  memory accepted store
mem_req  out  1  store request
mem_addr  out  32  store address, stable while mem_req=1
mem_wdata  out  32  store data, stable while mem_req=1
rf_w_en  out  1  register file write strobe
rf_w_idx  out  5  register file index
rf_w_val  out  32  register file data
pc_w_en  out  1  PC write strobe
pc_w_val  out  32  next PC
busy  out  1  instruction in flight (state != IDLE)
done  out  1  commit completed, one-cycle pulse
err_misaligned  out  1  one-cycle pulse: redirect target[1:0] != 0
err_timeout  out  1  one-cycle pulse: store abandoned
overrun  out  1  one-cycle pulse: op arrived while busy

Behaviour:
- Reset behaviour:
  - sys_rst high at a rising edge sets state to IDLE, clears latches and counter, and drives every output to 0 in the following cycle.
  - Reset overrides any state, including mid-store: mem_req drops with no commit and no done.
- Inputs come from negedge-registered execute outputs; they are stable at each rising edge.
- States:
  - IDLE:
    - Outputs 0.
    - op=1 latches all inputs.
    - Next state is MEM_WAIT if mem_w_op=1, else COMMIT.
  - MEM_WAIT:
    - mem_req=1; mem_addr/mem_wdata hold latched values.
    - Counter increments each edge.
    - mem_ack=1 at an edge goes to COMMIT.
    - Counter reaching TIMEOUT_CYCLES with mem_ack=0 goes to COMMIT with timeout latched.
    - mem_ack=1 on the same edge the counter hits the limit counts as success.
  - COMMIT:
    - Lasts exactly one cycle, then IDLE. Strobes are decoded from registered state and latches only (glitch-free).
    - done=1.
    - err_timeout=1 if timeout was latched.
    - Target = reg_pc_w_val if reg_pc_w_op, else reg_pc_val+4 (modulo 2^32, wraps 32'hFFFFFFFC to 0).
    - If reg_pc_w_op and target[1:0]!=0:
      - err_misaligned=1
      - rf_w_en=0
      - pc_w_en=0
    - Otherwise:
      - pc_w_en=1, pc_w_val=target.
      - rf_w_en=1 only if reg_w_op=1 and idx!=0 (x0 writes suppressed).
- Latency (op sampled at edge k):
  - Non-store: commit strobes high in the cycle after edge k.
  - Store: mem_req high in the cycle after edge k; commit in the cycle after the ack edge.
- An op sampled while state != IDLE (including COMMIT) is dropped, with overrun pulsed in the next cycle. No latch is updated.
- Store plus redirect together (not legal RV32I but possible): the store completes first, then the commit applies the redirect.
- mem_ack while not in MEM_WAIT is ignored.

Test Plan:
- ALU result: op with reg_w_op=1, idx=5, val=32'h1234, pc=32'h100 -> next cycle rf_w_en=1 idx5 val 32'h1234, pc_w_en=1 pc_w_val=32'h104, done=1; cycle after, all strobes 0.
- x0 write plus PC wrap: idx=0 val=32'hDEAD, pc=32'hFFFFFFFC -> rf_w_en=0, pc_w_val=32'h0, done=1.
- Store with ack after 3 cycles: addr 32'h2000 data 32'hA5A5A5A5 -> mem_req high 3 cycles, addr/data stable; commit cycle after ack, pc_w_val=pc+4, err_timeout=0.
- Timeout boundary with TIMEOUT_CYCLES=4:
  - No ack -> mem_req drops after 4 cycles; COMMIT has err_timeout=1, done=1.
  - Repeat with ack on the 4th edge -> err_timeout=0.
- JAL misaligned: reg_pc_w_op=1, target 32'h102, reg_w_op=1 idx=1 -> err_misaligned=1, rf_w_en=0, pc_w_en=0, done=1. Aligned target 32'h104 -> pc_w_val=32'h104, rf write occurs.
- Overrun and reset:
  - Second op during MEM_WAIT -> overrun pulse; first store completes unaffected.
  - sys_rst asserted mid-MEM_WAIT -> mem_req=0 next cycle, no done; IDLE accepts a new op afterwards.

Source files
------------

// File: rtl/ins_write_back.sv
// ins_write_back: commit stage directly behind instruction execute.
//
// Takes one execute result per `op` pulse. The result can ask for a register
// write, a word store and a PC redirect. A store is carried out first over a
// req/ack memory port. A single-cycle commit of the register file and PC then
// follows, in program order.
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   op                        execute result valid (one-cycle pulse)
//   reg_w_op/_reg_idx/_reg_val   rd write request
//   mem_w_op/_mem_addr/_mem_val  word store request
//   reg_pc_w_op, reg_pc_w_val    PC redirect request and target
//   reg_pc_val                PC of the committing instruction
//   mem_ack / mem_req, mem_addr, mem_wdata   store handshake
//   rf_w_en, rf_w_idx, rf_w_val   register file write port
//   pc_w_en, pc_w_val         PC write port
//   busy, done                in-flight flag, commit-complete pulse
//   err_misaligned, err_timeout, overrun   one-cycle status pulses
module ins_write_back #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        op,
   input  logic        reg_w_op,
   input  logic [4:0]  reg_w_reg_idx,
   input  logic [31:0] reg_w_reg_val,
   input  logic        mem_w_op,
   input  logic [31:0] mem_w_mem_addr,
   input  logic [31:0] mem_w_mem_val,
   input  logic        reg_pc_w_op,
   input  logic [31:0] reg_pc_w_val,
   input  logic [31:0] reg_pc_val,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        rf_w_en,
   output logic [4:0]  rf_w_idx,
   output logic [31:0] rf_w_val,
   output logic        pc_w_en,
   output logic [31:0] pc_w_val,
   output logic        busy,
   output logic        done,
   output logic        err_misaligned,
   output logic        err_timeout,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, MEM_WAIT, COMMIT} state_t;

   // The counter holds the number of MEM_WAIT edges already spent. The edge
   // that sees CNT_LAST is the TIMEOUT_CYCLES-th edge in MEM_WAIT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             timed_out;
   logic             overrun_q;
   logic             lat_reg_w_op;
   logic             lat_pc_w_op;
   logic [4:0]       lat_idx;
   logic [31:0]      lat_reg_val;
   logic [31:0]      lat_mem_addr;
   logic [31:0]      lat_mem_val;
   logic [31:0]      lat_pc_w_val;
   logic [31:0]      lat_pc_val;

   function automatic logic [31:0] commit_target(input logic        redirect,
                                                 input logic [31:0] redirect_val,
                                                 input logic [31:0] pc);
      // Sequential PC wraps modulo 2^32 (32'hFFFFFFFC -> 0).
      return redirect ? redirect_val : pc + 32'd4;
   endfunction

   // Control: state, wait counter, timeout and request flags
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         timed_out    <= 1'b0;
         overrun_q    <= 1'b0;
         lat_reg_w_op <= 1'b0;
         lat_pc_w_op  <= 1'b0;
      end else begin
         overrun_q <= op && (state != IDLE);
         case (state)
            IDLE: begin
               if (op) begin
                  lat_reg_w_op <= reg_w_op;
                  lat_pc_w_op  <= reg_pc_w_op;
                  cnt          <= '0;
                  timed_out    <= 1'b0;
                  state        <= mem_w_op ? MEM_WAIT : COMMIT;
               end
            end
            MEM_WAIT: begin
               // An ack on the limit edge still counts as success.
               if (mem_ack) begin
                  state <= COMMIT;
               end else if (cnt == CNT_LAST) begin
                  timed_out <= 1'b1;
                  state     <= COMMIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            COMMIT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Payload latches: only captured when an op is accepted; outputs are
   // gated by state, so stale payload is never visible.
   always_ff @(posedge sys_clk) begin
      if (op && (state == IDLE)) begin
         lat_idx      <= reg_w_reg_idx;
         lat_reg_val  <= reg_w_reg_val;
         lat_mem_addr <= mem_w_mem_addr;
         lat_mem_val  <= mem_w_mem_val;
         lat_pc_w_val <= reg_pc_w_val;
         lat_pc_val   <= reg_pc_val;
      end
   end

   // Output decode: driven only from registered state and latches
   logic        in_commit;
   logic        misaligned;
   logic [31:0] target;

   always_comb begin
      in_commit  = (state == COMMIT);
      target     = commit_target(lat_pc_w_op, lat_pc_w_val, lat_pc_val);
      misaligned = lat_pc_w_op && (target[1:0] != 2'b00);

      mem_req        = (state == MEM_WAIT);
      mem_addr       = mem_req ? lat_mem_addr : 32'd0;
      mem_wdata      = mem_req ? lat_mem_val  : 32'd0;

      done           = in_commit;
      err_misaligned = in_commit && misaligned;
      err_timeout    = in_commit && timed_out;
      pc_w_en        = in_commit && !misaligned;
      pc_w_val       = pc_w_en ? target : 32'd0;
      // x0 writes are suppressed.
      rf_w_en        = pc_w_en && lat_reg_w_op && (lat_idx != 5'd0);
      rf_w_idx       = rf_w_en ? lat_idx     : 5'd0;
      rf_w_val       = rf_w_en ? lat_reg_val : 32'd0;

      busy           = (state != IDLE);
      overrun        = overrun_q;
   end

endmodule

// File: tb/tb_ins_write_back.sv
module tb_ins_write_back;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        op;
   logic        reg_w_op;
   logic [4:0]  reg_w_reg_idx;
   logic [31:0] reg_w_reg_val;
   logic        mem_w_op;
   logic [31:0] mem_w_mem_addr;
   logic [31:0] mem_w_mem_val;
   logic        reg_pc_w_op;
   logic [31:0] reg_pc_w_val;
   logic [31:0] reg_pc_val;
   logic        mem_ack;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        rf_w_en;
   logic [4:0]  rf_w_idx;
   logic [31:0] rf_w_val;
   logic        pc_w_en;
   logic [31:0] pc_w_val;
   logic        busy;
   logic        done;
   logic        err_misaligned;
   logic        err_timeout;
   logic        overrun;

   int total = 0;
   int bad   = 0;

   ins_write_back #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .op(op),
      .reg_w_op(reg_w_op), .reg_w_reg_idx(reg_w_reg_idx), .reg_w_reg_val(reg_w_reg_val),
      .mem_w_op(mem_w_op), .mem_w_mem_addr(mem_w_mem_addr), .mem_w_mem_val(mem_w_mem_val),
      .reg_pc_w_op(reg_pc_w_op), .reg_pc_w_val(reg_pc_w_val), .reg_pc_val(reg_pc_val),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .rf_w_en(rf_w_en), .rf_w_idx(rf_w_idx), .rf_w_val(rf_w_val),
      .pc_w_en(pc_w_en), .pc_w_val(pc_w_val), .busy(busy), .done(done),
      .err_misaligned(err_misaligned), .err_timeout(err_timeout), .overrun(overrun)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge, then settle 1 ns past it.
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_inputs();
      op = 0; reg_w_op = 0; reg_w_reg_idx = 0; reg_w_reg_val = 0;
      mem_w_op = 0; mem_w_mem_addr = 0; mem_w_mem_val = 0;
      reg_pc_w_op = 0; reg_pc_w_val = 0; reg_pc_val = 0; mem_ack = 0;
   endtask

   task automatic issue(input logic rw, input logic [4:0] idx, input logic [31:0] rval,
                        input logic mw, input logic [31:0] maddr, input logic [31:0] mval,
                        input logic pw, input logic [31:0] pwval, input logic [31:0] pc);
      op = 1; reg_w_op = rw; reg_w_reg_idx = idx; reg_w_reg_val = rval;
      mem_w_op = mw; mem_w_mem_addr = maddr; mem_w_mem_val = mval;
      reg_pc_w_op = pw; reg_pc_w_val = pwval; reg_pc_val = pc;
   endtask

   task automatic chk_commit(input string tag, input logic rfe, input logic [4:0] idx,
                             input logic [31:0] val, input logic pce, input logic [31:0] pcv,
                             input logic mis, input logic tmo);
      chk({tag, ".done"}, done, 1);
      chk({tag, ".rf_w_en"}, rf_w_en, rfe);
      if (rfe) begin
         chk({tag, ".rf_w_idx"}, rf_w_idx, idx);
         chk({tag, ".rf_w_val"}, rf_w_val, val);
      end
      chk({tag, ".pc_w_en"}, pc_w_en, pce);
      if (pce) chk({tag, ".pc_w_val"}, pc_w_val, pcv);
      chk({tag, ".err_misaligned"}, err_misaligned, mis);
      chk({tag, ".err_timeout"}, err_timeout, tmo);
      chk({tag, ".mem_req"}, mem_req, 0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".rf_w_en"}, rf_w_en, 0);
      chk({tag, ".pc_w_en"}, pc_w_en, 0);
      chk({tag, ".mem_req"}, mem_req, 0);
   endtask

   initial begin
      clear_inputs();
      sys_rst = 1;
      step();
      step();
      // Reset state: every output low
      chk_quiet("rst");
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.overrun", overrun, 0);
      chk("rst.err_timeout", err_timeout, 0);
      chk("rst.err_misaligned", err_misaligned, 0);
      sys_rst = 0;
      step();

      // ALU result
      issue(1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 32'h100);
      step();
      clear_inputs();
      chk_commit("alu", 1, 5'd5, 32'h1234, 1, 32'h104, 0, 0);
      chk("alu.busy", busy, 1);
      step();
      chk_quiet("alu_after");

      // x0 write plus PC wrap
      issue(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0, 32'hFFFFFFFC);
      step();
      clear_inputs();
      chk_commit("x0wrap", 0, 0, 0, 1, 32'h0, 0, 0);
      step();
      chk_quiet("x0wrap_after");

      // ack while idle is ignored
      mem_ack = 1;
      step();
      mem_ack = 0;
      chk_quiet("idle_ack");

      // Store, ack after 3 cycles
      issue(0, 0, 0, 1, 32'h2000, 32'hA5A5A5A5, 0, 0, 32'h200);
      step();
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         chk("st.mem_req", mem_req, 1);
         chk("st.mem_addr", mem_addr, 32'h2000);
         chk("st.mem_wdata", mem_wdata, 32'hA5A5A5A5);
         chk("st.done", done, 0);
         if (i == 2) mem_ack = 1;
         step();
      end
      mem_ack = 0;
      chk_commit("st", 0, 0, 0, 1, 32'h204, 0, 0);
      step();
      chk_quiet("st_after");

      // Timeout, no ack (TIMEOUT_CYCLES=4)
      issue(0, 0, 0, 1, 32'h3000, 32'h1, 0, 0, 32'h300);
      step();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         chk("tmo.mem_req", mem_req, 1);
         step();
      end
      chk_commit("tmo", 0, 0, 0, 1, 32'h304, 0, 1);
      step();
      chk_quiet("tmo_after");

      // Ack on the 4th edge counts as success
      issue(0, 0, 0, 1, 32'h3004, 32'h2, 0, 0, 32'h308);
      step();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         chk("ack4.mem_req", mem_req, 1);
         if (i == 3) mem_ack = 1;
         step();
      end
      mem_ack = 0;
      chk_commit("ack4", 0, 0, 0, 1, 32'h30C, 0, 0);
      step();

      // JAL misaligned target
      issue(1, 5'd1, 32'h104, 0, 0, 0, 1, 32'h102, 32'h100);
      step();
      clear_inputs();
      chk_commit("jal_mis", 0, 0, 0, 0, 0, 1, 0);
      step();

      // JAL aligned target
      issue(1, 5'd1, 32'h104, 0, 0, 0, 1, 32'h104, 32'h100);
      step();
      clear_inputs();
      chk_commit("jal_ok", 1, 5'd1, 32'h104, 1, 32'h104, 0, 0);
      step();

      // Store plus redirect: store first, then redirect
      issue(0, 0, 0, 1, 32'h4000, 32'h77, 1, 32'h800, 32'h500);
      step();
      clear_inputs();
      chk("stjmp.mem_req", mem_req, 1);
      mem_ack = 1;
      step();
      mem_ack = 0;
      chk_commit("stjmp", 0, 0, 0, 1, 32'h800, 0, 0);
      step();

      // Overrun during MEM_WAIT
      issue(0, 0, 0, 1, 32'h3000, 32'h11223344, 0, 0, 32'h400);
      step();
      clear_inputs();
      issue(1, 5'd7, 32'h99, 0, 0, 0, 0, 0, 32'h800);
      step();
      clear_inputs();
      chk("ovr.overrun", overrun, 1);
      chk("ovr.mem_req", mem_req, 1);
      chk("ovr.mem_addr", mem_addr, 32'h3000);
      chk("ovr.mem_wdata", mem_wdata, 32'h11223344);
      mem_ack = 1;
      step();
      mem_ack = 0;
      chk("ovr.overrun_clr", overrun, 0);
      chk_commit("ovr", 0, 0, 0, 1, 32'h404, 0, 0);
      step();
      chk_quiet("ovr_after");

      // Overrun during COMMIT: dropped op produces no commit
      issue(1, 5'd2, 32'h5, 0, 0, 0, 0, 0, 32'h600);
      step();
      issue(1, 5'd3, 32'h6, 0, 0, 0, 0, 0, 32'h700);
      step();
      clear_inputs();
      chk("ovrc.overrun", overrun, 1);
      chk_quiet("ovrc");
      step();
      chk_quiet("ovrc_after");

      // Reset mid-MEM_WAIT
      issue(0, 0, 0, 1, 32'h5000, 32'h9, 0, 0, 32'h900);
      step();
      clear_inputs();
      chk("rstmid.mem_req", mem_req, 1);
      sys_rst = 1;
      step();
      sys_rst = 0;
      chk_quiet("rstmid");
      chk("rstmid.mem_addr", mem_addr, 0);
      step();
      chk_quiet("rstmid_after");

      // New op after reset
      issue(1, 5'd3, 32'h55, 0, 0, 0, 0, 0, 32'h600);
      step();
      clear_inputs();
      chk_commit("post_rst", 1, 5'd3, 32'h55, 1, 32'h604, 0, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
